xy_switch_allocator: RTL and testbench

// - Wormhole switch allocator for one mesh router. It sits between the per-input xy_router

---
 rtl/xy_switch_allocator.sv | 112 +++++++++++
 tb/tb_xy_switch_allocator.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/xy_switch_allocator.sv
// rtl/xy_switch_allocator.sv - wormhole switch allocator with per-output round-robin lock
module xy_switch_allocator #(
    parameter int IN_N    = 5,
    parameter int OUT_N   = 5,
    parameter int OUT_N_W = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [IN_N-1:0]           in_req_i,
    input  logic [IN_N*OUT_N_W-1:0]   in_dest_i,
    input  logic [IN_N-1:0]           in_last_i,
    input  logic [OUT_N-1:0]          out_ready_i,
    output logic [IN_N-1:0]           in_grant_o,
    output logic [OUT_N-1:0]          out_valid_o,
    output logic [OUT_N*IN_N-1:0]     out_sel_o,
    output logic [OUT_N-1:0]          out_lock_o
);
    localparam int IN_W = (IN_N > 1) ? $clog2(IN_N) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state [OUT_N];
    logic [IN_W-1:0] own   [OUT_N];
    logic [IN_W-1:0] ptr   [OUT_N];
    logic [IN_N-1:0] sel   [OUT_N];

    logic [IN_N-1:0]  busy_in;
    logic [IN_N-1:0]  req  [OUT_N];
    logic [IN_W-1:0]  pick [OUT_N];
    logic [OUT_N-1:0] found;
    logic [OUT_N-1:0] xfer;
    logic [OUT_N-1:0] tail;

    // sel is cleared on release, so the OR of all selects marks every owning input
    always_comb begin
        busy_in = '0;
        for (int o = 0; o < OUT_N; o++) begin
            busy_in = busy_in | sel[o];
        end
    end

    always_comb begin
        for (int o = 0; o < OUT_N; o++) begin
            for (int i = 0; i < IN_N; i++) begin
                req[o][i] = in_req_i[i] && !busy_in[i] &&
                            (in_dest_i[i*OUT_N_W +: OUT_N_W] == OUT_N_W'(o));
            end
        end
    end

    // Round-robin search starts just past the last owner and wraps
    always_comb begin
        logic [IN_W-1:0] idx;
        idx = '0;
        for (int o = 0; o < OUT_N; o++) begin
            found[o] = 1'b0;
            pick[o]  = '0;
            for (int k = 1; k <= IN_N; k++) begin
                idx = IN_W'((int'(ptr[o]) + k) % IN_N);
                if (!found[o] && req[o][idx]) begin
                    found[o] = 1'b1;
                    pick[o]  = idx;
                end
            end
        end
    end

    always_comb begin
        in_grant_o = '0;
        out_sel_o  = '0;
        for (int o = 0; o < OUT_N; o++) begin
            out_lock_o[o]  = (state[o] == LOCKED);
            out_valid_o[o] = out_lock_o[o] && |(in_req_i & sel[o]);
            xfer[o]        = out_valid_o[o] && out_ready_i[o];
            tail[o]        = xfer[o] && |(in_last_i & sel[o]);
            if (xfer[o]) begin
                in_grant_o = in_grant_o | sel[o];
            end
            out_sel_o[o*IN_N +: IN_N] = sel[o];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int o = 0; o < OUT_N; o++) begin
                state[o] <= IDLE;
                own[o]   <= '0;
                sel[o]   <= '0;
                ptr[o]   <= IN_W'(IN_N - 1);
            end
        end else begin
            for (int o = 0; o < OUT_N; o++) begin
                case (state[o])
                    IDLE: begin
                        if (found[o]) begin
                            state[o] <= LOCKED;
                            own[o]   <= pick[o];
                            sel[o]   <= IN_N'(1) << pick[o];
                        end
                    end
                    LOCKED: begin
                        if (tail[o]) begin
                            state[o] <= IDLE;
                            sel[o]   <= '0;
                            ptr[o]   <= own[o];
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_xy_switch_allocator.sv
// tb/tb_xy_switch_allocator.sv - directed bench with grant scoreboard for xy_switch_allocator
module tb_xy_switch_allocator;
    localparam int IN_N    = 5;
    localparam int OUT_N   = 5;
    localparam int OUT_N_W = 3;
    localparam int DW      = IN_N * OUT_N_W;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [IN_N-1:0]  req;
    logic [IN_N-1:0]  last;
    logic [IN_N-1:0]  grant;
    logic [DW-1:0]    dest;
    logic [OUT_N-1:0] ready;
    logic [OUT_N-1:0] valid;
    logic [OUT_N-1:0] lock;
    logic [OUT_N*IN_N-1:0] sel;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    bit started = 1'b0;

    typedef struct {
        int              c;
        logic [IN_N-1:0] g;
    } exp_t;
    exp_t exp_q[$];

    xy_switch_allocator #(
        .IN_N(IN_N), .OUT_N(OUT_N), .OUT_N_W(OUT_N_W)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .in_req_i(req),
        .in_dest_i(dest),
        .in_last_i(last),
        .out_ready_i(ready),
        .in_grant_o(grant),
        .out_valid_o(valid),
        .out_sel_o(sel),
        .out_lock_o(lock)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic [IN_N-1:0] g);
        exp_t e;
        e.c = c;
        e.g = g;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        req   = '0;
        last  = '0;
        dest  = {IN_N{3'd7}};
        ready = '1;
    endtask

    task automatic set_dest(input int i, input logic [OUT_N_W-1:0] d);
        dest[i*OUT_N_W +: OUT_N_W] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Every nonzero grant must match the next scoreboard entry in value and cycle
    always @(negedge clk) begin
        exp_t e;
        if (started && grant !== '0) begin
            if (exp_q.size() == 0) begin
                chk("grant_unexpected", 32'(grant), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("grant_cycle", 32'(cyc), 32'(e.c));
                chk("grant_val", 32'(grant), 32'(e.g));
            end
        end
    end

    initial begin
        int c0;
        idle_inputs();

        for (int k = 0; k < 2; k++) begin
            step();
            req     = IN_N'($urandom);
            last    = IN_N'($urandom);
            dest    = DW'($urandom);
            ready   = OUT_N'($urandom);
            started = 1'b1;
            sample();
            chk("rst_grant", 32'(grant), 32'd0);
            chk("rst_valid", 32'(valid), 32'd0);
            chk("rst_sel",   32'(sel),   32'd0);
            chk("rst_lock",  32'(lock),  32'd0);
        end
        step();
        rst_n = 1'b1;
        idle_inputs();
        sample();

        // single 3-flit packet, input 1 to output 3
        step();
        c0 = cyc;
        req[1] = 1'b1;
        set_dest(1, 3'd3);
        push(c0 + 1, 5'b00010);
        push(c0 + 2, 5'b00010);
        push(c0 + 3, 5'b00010);
        sample();
        chk("pkt_lock_c0", 32'(lock[3]), 32'd0);
        step(); sample();
        chk("pkt_lock_c1", 32'(lock[3]), 32'd1);
        step(); sample();
        chk("pkt_lock_c2", 32'(lock[3]), 32'd1);
        step(); last[1] = 1'b1; sample();
        chk("pkt_lock_c3", 32'(lock[3]), 32'd1);
        step(); idle_inputs(); sample();
        chk("pkt_lock_c4", 32'(lock[3]), 32'd0);

        // contention on output 0 from inputs 0, 2, 4
        step();
        c0 = cyc;
        req  = 5'b10101;
        last = 5'b10101;
        set_dest(0, 3'd0);
        set_dest(2, 3'd0);
        set_dest(4, 3'd0);
        push(c0 + 1, 5'b00001);
        push(c0 + 3, 5'b00100);
        push(c0 + 5, 5'b10000);
        push(c0 + 7, 5'b00001);
        sample();
        chk("cont_lock", 32'(lock[0]), 32'd0);
        for (int k = 1; k < 8; k++) begin
            step(); sample();
            chk("cont_lock", 32'(lock[0]), 32'(k % 2));
        end
        step(); idle_inputs(); sample();
        chk("cont_release", 32'(lock[0]), 32'd0);

        // back-pressure on output 1 owned by input 2
        step();
        c0 = cyc;
        req[2] = 1'b1;
        set_dest(2, 3'd1);
        push(c0 + 4, 5'b00100);
        push(c0 + 5, 5'b00100);
        sample();
        for (int k = 1; k < 4; k++) begin
            step(); ready[1] = 1'b0; sample();
            chk("bp_grant", 32'(grant),    32'd0);
            chk("bp_valid", 32'(valid[1]), 32'd1);
            chk("bp_lock",  32'(lock[1]),  32'd1);
        end
        step(); ready[1] = 1'b1; sample();
        chk("bp_resume_lock", 32'(lock[1]), 32'd1);
        step(); last[2] = 1'b1; sample();
        step(); idle_inputs(); sample();
        chk("bp_release", 32'(lock[1]), 32'd0);

        // parallel allocation: 0 -> 4 and 3 -> 2
        step();
        c0 = cyc;
        req  = 5'b01001;
        last = 5'b01001;
        set_dest(0, 3'd4);
        set_dest(3, 3'd2);
        push(c0 + 1, 5'b01001);
        sample();
        chk("par_lock_c0", 32'(lock), 32'd0);
        step(); sample();
        chk("par_lock", 32'(lock), 32'b10100);
        chk("par_sel4", 32'(sel[4*IN_N +: IN_N]), 32'b00001);
        chk("par_sel2", 32'(sel[2*IN_N +: IN_N]), 32'b01000);
        step(); idle_inputs(); sample();
        chk("par_release", 32'(lock), 32'd0);

        // route beyond the output range never allocates
        step(); req[2] = 1'b1; set_dest(2, 3'd5); sample();
        step(); sample();
        chk("bad_route_lock", 32'(lock), 32'd0);
        step(); idle_inputs(); sample();

        // reset in the middle of a 4-flit packet, then a fresh head
        step();
        c0 = cyc;
        req[1] = 1'b1;
        set_dest(1, 3'd3);
        push(c0 + 1, 5'b00010);
        push(c0 + 2, 5'b00010);
        sample();
        step(); sample();
        step(); sample();
        step(); rst_n = 1'b0; req = '0; sample();
        chk("mid_lock_held", 32'(lock[3]), 32'd1);
        step();
        rst_n = 1'b1;
        c0 = cyc;
        req[1] = 1'b1;
        set_dest(1, 3'd3);
        push(c0 + 1, 5'b00010);
        sample();
        chk("mid_lock_cleared", 32'(lock[3]), 32'd0);
        step(); last[1] = 1'b1; sample();
        chk("realloc_lock", 32'(lock[3]), 32'd1);
        step(); idle_inputs(); sample();
        chk("realloc_release", 32'(lock[3]), 32'd0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
